// File: rtl/masked_share_gen_pkg.sv
// Shared types and defaults for the operand-masking stage ahead of the masked adder.
// Holds the LFSR defaults and the share-set record carried by the output register.
package masked_share_gen_pkg;

    localparam int SHARE_N    = 4;
    localparam int LFSR_W_DEF = 16;

    localparam logic [15:0] SEED_DEF = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Galois form
    localparam logic [15:0] TAPS_DEF = 16'hB400;

    typedef struct packed {
        logic [SHARE_N-1:0] a0;
        logic [SHARE_N-1:0] a1;
        logic [SHARE_N-1:0] b0;
        logic [SHARE_N-1:0] b1;
    } share_t;

    // Boolean masking: the mask itself is share 1, the masked operand is share 0.
    function automatic share_t mask_operands(
        input logic [SHARE_N-1:0] a,
        input logic [SHARE_N-1:0] b,
        input logic [SHARE_N-1:0] ma,
        input logic [SHARE_N-1:0] mb
    );
        share_t s;
        s.a0 = a ^ ma;
        s.a1 = ma;
        s.b0 = b ^ mb;
        s.b1 = mb;
        return s;
    endfunction

endpackage

// File: rtl/masked_share_gen_share_lfsr.sv
// Free-running Galois LFSR mask source; output is the current state, no latency.
// Reseed takes priority over advance; a zero seed falls back to SEED so the state is never zero.
module share_lfsr #(
    parameter int              W    = 16,
    parameter logic [W-1:0]    SEED = 16'hACE1,
    parameter logic [W-1:0]    TAPS = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [W-1:0] seed_in,
    output logic [W-1:0] lfsr
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_step;

    assign lfsr_step = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (seed_load) begin
            lfsr_q <= (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr_q <= lfsr_step;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/masked_share_gen.sv
// Splits plain operands into Boolean share pairs; 1-cycle latency accept -> out_valid.
// One-entry output register: holds while out_ready is low, streams at full rate otherwise.
module masked_share_gen
    import masked_share_gen_pkg::*;
#(
    parameter int                 N      = SHARE_N,
    parameter int                 LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(SEED_DEF),
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(TAPS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      a0,
    output logic [N-1:0]      a1,
    output logic [N-1:0]      b0,
    output logic [N-1:0]      b1,
    output logic [15:0]       txn_cnt
);

    if (2 * N > LFSR_W) begin : g_bad_width
        $error("masked_share_gen: 2*N must not exceed LFSR_W");
    end
    if (N != SHARE_N) begin : g_bad_share_w
        $error("masked_share_gen: N must match the package share width");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("masked_share_gen: SEED must be non-zero");
    end

    logic [LFSR_W-1:0] lfsr_val;
    logic [N-1:0]      ma;
    logic [N-1:0]      mb;
    logic              accept;
    share_t            share_q;
    logic              out_valid_q;
    logic [15:0]       txn_cnt_q;

    share_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr      (lfsr_val)
    );

    // Masks come from the pre-update LFSR value, so a concurrent reseed never affects this set.
    assign ma = lfsr_val[N-1:0];
    assign mb = lfsr_val[2*N-1:N];

    if (2 * N < LFSR_W) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:2*N];
    end

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            share_q     <= '0;
            txn_cnt_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            share_q     <= mask_operands(a, b, ma, mb);
            txn_cnt_q   <= txn_cnt_q + 16'd1;
        end else if (out_ready) begin
            // Drain without refill: shares keep their last value, only valid drops.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign a0        = share_q.a0;
    assign a1        = share_q.a1;
    assign b0        = share_q.b0;
    assign b1        = share_q.b1;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_masked_share_gen.sv
// Self-checking bench for masked_share_gen: vector table, corner sequences, random stream vs model.
module tb_masked_share_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [3:0]  b0;
    logic [3:0]  b1;
    logic [15:0] txn_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    masked_share_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .txn_cnt   (txn_cnt)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] b0;
        logic [3:0] b1;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ma;
        logic [3:0] mb;
    } exp_t;

    // Reference LFSR as polynomial arithmetic: multiply state by x^-1 modulo the feedback polynomial.
    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic [16:0] t;
        t = {1'b0, v};
        if (v[0]) t = t ^ {16'h0, 1'b1} ^ 17'h16801;
        return t[16:1];
    endfunction

    function automatic logic [15:0] ref_adv(input logic [15:0] v, input int k);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = ref_next(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        seed_load = 1'b0;
        seed_in   = 16'h0;
        out_ready = 1'b1;
    endtask

    // Leaves the bench in the first post-reset cycle (lfsr == ACE1).
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t       vecs[4];
    exp_t       expq[$];
    exp_t       e;
    logic [15:0] model;
    logic [3:0]  ma_s;
    logic [3:0]  mb_s;
    int          delivered;
    int          accepted;
    int          cyc;
    int          nsteps;
    bit          zero_seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 4'h5, b: 4'h3, a0: 4'h4, a1: 4'h1, b0: 4'hD, b1: 4'hE};
        vecs[1] = '{a: 4'hA, b: 4'hF, a0: 4'hA, a1: 4'h0, b0: 4'h8, b1: 4'h7};
        vecs[2] = '{a: 4'hF, b: 4'h0, a0: 4'h7, a1: 4'h8, b0: 4'h3, b1: 4'h3};
        vecs[3] = '{a: 4'h0, b: 4'h6, a0: 4'hC, a1: 4'hC, b0: 4'hF, b1: 4'h9};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_txn_cnt", txn_cnt, 0);
        check("rst_shares", {a0, a1, b0, b1}, 0);
        check("rst_lfsr", dut.lfsr_val, 16'hACE1);
        rst = 1'b0;

        // Back-to-back vectors from the known post-reset LFSR sequence
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = vecs[i].a;
            b = vecs[i].b;
            #1;
            check("vec_in_ready", in_ready, 1);
            step();
            check($sformatf("vec%0d_shares", i), {a0, a1, b0, b1},
                  {vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1});
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_txn", i), txn_cnt, i + 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_hold_shares", {a0, a1, b0, b1}, {4'hC, 4'hC, 4'hF, 4'h9});

        // LFSR first step
        do_reset();
        check("lfsr_start", dut.lfsr_val, 16'hACE1);
        step();
        check("lfsr_step1", dut.lfsr_val, ref_next(16'hACE1));
        check("lfsr_step1_const", dut.lfsr_val, 16'hE270);

        // Backpressure: hold for 5 cycles, then accept next with no bubble
        do_reset();
        in_valid = 1'b1;
        a = 4'h5;
        b = 4'h3;
        step();
        out_ready = 1'b0;
        a = 4'hA;
        b = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_shares", {a0, a1, b0, b1}, {4'h4, 4'h1, 4'hD, 4'hE});
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_txn", txn_cnt, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        model = ref_adv(16'hACE1, 6);
        step();
        check("release_valid", out_valid, 1);
        check("release_txn", txn_cnt, 2);
        check("release_shares", {a0, a1, b0, b1},
              {4'hA ^ model[3:0], model[3:0], 4'hF ^ model[7:4], model[7:4]});
        in_valid = 1'b0;

        // Reseed: zero falls back to default, non-zero loads verbatim
        seed_load = 1'b1;
        seed_in   = 16'h0;
        step();
        check("seed_zero", dut.lfsr_val, 16'hACE1);
        seed_in = 16'h1234;
        step();
        check("seed_1234", dut.lfsr_val, 16'h1234);
        // Reseed concurrent with accept: masks from pre-load value 1234
        seed_in  = 16'h5555;
        in_valid = 1'b1;
        a = 4'h9;
        b = 4'h6;
        step();
        check("seed_accept_lfsr", dut.lfsr_val, 16'h5555);
        check("seed_accept_shares", {a0, a1, b0, b1}, {4'hD, 4'h4, 4'h5, 4'h3});
        idle_inputs();

        // Random stream against a queue model
        do_reset();
        model     = 16'hACE1;
        delivered = 0;
        accepted  = 0;
        cyc       = 0;
        while (delivered < 1000 && cyc < 20000) begin
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            a         = 4'($urandom);
            b         = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("stream_spurious", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("stream_a", a0 ^ a1, e.a);
                    check("stream_b", b0 ^ b1, e.b);
                    check("stream_masks", {a1, b1}, {e.ma, e.mb});
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                ma_s = model[3:0];
                mb_s = model[7:4];
                expq.push_back('{a: a, b: b, ma: ma_s, mb: mb_s});
                accepted++;
            end
            step();
            model = ref_next(model);
            cyc++;
        end
        check("stream_delivered", delivered, 1000);
        check("stream_queue_empty", expq.size(), 0);
        check("stream_txn", txn_cnt, 1000);
        idle_inputs();

        // Reset while a share set is held
        do_reset();
        in_valid = 1'b1;
        a = 4'h7;
        b = 4'h2;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_mid_held", out_valid, 1);
        rst = 1'b1;
        step();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_txn", txn_cnt, 0);
        check("rst_mid_lfsr", dut.lfsr_val, 16'hACE1);
        check("rst_mid_in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_mid_no_deliver", out_valid, 0);

        // Full period: 65535 steps back to the seed, never zero on the way
        do_reset();
        nsteps    = 0;
        zero_seen = 1'b0;
        do begin
            step();
            nsteps++;
            if (dut.lfsr_val == 16'h0) zero_seen = 1'b1;
        end while (dut.lfsr_val != 16'hACE1 && nsteps < 70000);
        check("lfsr_period", nsteps, 65535);
        check("lfsr_never_zero", zero_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
